// File: rtl/solar_scan_sequencer.sv
// solar_scan_sequencer: scans N/E/S/W light sensors through one shared ADC,
// compares opposite pairs with hysteresis and pulses one tracker motor.
module solar_scan_sequencer #(
  parameter logic [7:0] TH          = 8'd10,
  parameter int         SETTLE      = 4,
  parameter int         MOVE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] adc_sel,
  output logic       adc_start,
  input  logic       adc_done,
  input  logic [7:0] adc_data,
  output logic       mn,
  output logic       me,
  output logic       ms,
  output logic       mw,
  output logic       scan_done
);

  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam int MW = (MOVE_CYCLES < 2) ? 1 : $clog2(MOVE_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_SETTLE,
    ST_START,
    ST_WAIT,
    ST_DECIDE,
    ST_MOVE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [MW-1:0] mcnt;
  logic [7:0]    s_n;
  logic [7:0]    s_e;
  logic [7:0]    s_s;
  logic [7:0]    s_w;

  logic [8:0] th9;
  logic       go_n;
  logic       go_e;
  logic       go_s;
  logic       go_w;

  // Pair comparisons in 9 bits so sample+TH never wraps.
  always_comb begin
    th9  = {1'b0, TH};
    go_n = {1'b0, s_n} > ({1'b0, s_s} + th9);
    go_e = {1'b0, s_e} > ({1'b0, s_w} + th9);
    go_s = {1'b0, s_s} > ({1'b0, s_n} + th9);
    go_w = {1'b0, s_w} > ({1'b0, s_e} + th9);
  end

  // Scan/decide/move sequencer; every output is a register.
  // The one-hot motor register doubles as the latched direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_SETTLE;
      cnt       <= '0;
      mcnt      <= '0;
      adc_sel   <= 2'd0;
      adc_start <= 1'b0;
      scan_done <= 1'b0;
      mn        <= 1'b0;
      me        <= 1'b0;
      ms        <= 1'b0;
      mw        <= 1'b0;
      s_n       <= 8'd0;
      s_e       <= 8'd0;
      s_s       <= 8'd0;
      s_w       <= 8'd0;
    end else begin
      adc_start <= 1'b0;
      scan_done <= 1'b0;
      unique case (state)
        ST_SETTLE: begin
          if (cnt == CW'(SETTLE - 1)) begin
            cnt       <= '0;
            adc_start <= 1'b1;
            state     <= ST_START;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_START: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (adc_done) begin
            unique case (adc_sel)
              2'd0: s_n <= adc_data;
              2'd1: s_e <= adc_data;
              2'd2: s_s <= adc_data;
              2'd3: s_w <= adc_data;
            endcase
            if (adc_sel == 2'd3) begin
              adc_sel   <= 2'd0;
              scan_done <= 1'b1;
              state     <= ST_DECIDE;
            end else begin
              adc_sel <= adc_sel + 2'd1;
              state   <= ST_SETTLE;
            end
          end
        end
        ST_DECIDE: begin
          mcnt  <= MW'(MOVE_CYCLES);
          state <= ST_MOVE;
          if (go_n) begin
            mn <= 1'b1;
          end else if (go_e) begin
            me <= 1'b1;
          end else if (go_s) begin
            ms <= 1'b1;
          end else if (go_w) begin
            mw <= 1'b1;
          end else begin
            state <= ST_SETTLE;
          end
        end
        ST_MOVE: begin
          mcnt <= mcnt - MW'(1);
          if (mcnt == MW'(1)) begin
            mn    <= 1'b0;
            me    <= 1'b0;
            ms    <= 1'b0;
            mw    <= 1'b0;
            state <= ST_SETTLE;
          end
        end
        default: begin
          state <= ST_SETTLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_solar_scan_sequencer.sv
// tb_solar_scan_sequencer: random + directed scans, ADC responder,
// event scoreboard checked by an independent output monitor.
module tb_solar_scan_sequencer;

  localparam int TH  = 10;
  localparam int SET = 4;
  localparam int MOV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] adc_sel;
  logic       adc_start;
  logic       adc_done = 1'b0;
  logic [7:0] adc_data = 8'd0;
  logic       mn;
  logic       me;
  logic       ms;
  logic       mw;
  logic       scan_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // kind: 0 = adc_start (val = sel), 1 = scan_done, 2 = motor run (val = dir)
  typedef struct {
    int kind;
    int val;
    int t;
  } ev_t;

  ev_t q[$];

  solar_scan_sequencer #(
    .TH(8'(TH)),
    .SETTLE(SET),
    .MOVE_CYCLES(MOV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .adc_sel(adc_sel),
    .adc_start(adc_start),
    .adc_done(adc_done),
    .adc_data(adc_data),
    .mn(mn),
    .me(me),
    .ms(ms),
    .mw(mw),
    .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference decision: first rule that holds, in N, E, S, W order.
  function automatic int ref_dir(int n, int e, int s, int w);
    if (n > s + TH) return 0;
    if (e > w + TH) return 1;
    if (s > n + TH) return 2;
    if (w > e + TH) return 3;
    return -1;
  endfunction

  function automatic int mdir();
    if (mn) return 0;
    if (me) return 1;
    if (ms) return 2;
    if (mw) return 3;
    return -1;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(int k, int v, int t);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.t    = t;
    q.push_back(e);
  endtask

  task automatic pop_ev(int kind, int val, int t, int len, string nm);
    ev_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: unexpected event val=%0d at cycle %0d, want none", nm, val, t);
      return;
    end
    e = q.pop_front();
    chk({nm, " kind"}, kind, e.kind);
    chk({nm, " val"}, val, e.val);
    chk({nm, " cycle"}, t, e.t);
    if (kind == 2) chk({nm, " length"}, len, MOV);
  endtask

  // Monitor
  int mcur = -1;
  int mt0  = 0;
  int mlen = 0;
  int md;

  always @(negedge clk) begin
    if (rst) begin
      mcur = -1;
      mlen = 0;
    end else begin
      md = mdir();
      chk("motor onehot", int'($countones({mn, me, ms, mw}) <= 1), 1);
      if (adc_start) pop_ev(0, int'(adc_sel), cyc, 0, "start");
      if (scan_done) pop_ev(1, 0, cyc, 0, "scan_done");
      if (mcur >= 0 && md == mcur) begin
        mlen++;
      end else begin
        if (mcur >= 0) pop_ev(2, mcur, mt0, mlen, "move");
        mcur = md;
        mt0  = cyc;
        mlen = (md >= 0) ? 1 : 0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Wait for adc_start, sprinkling ignored adc_done pulses with data 255.
  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      step();
      adc_done = 1'b0;
      adc_data = 8'd0;
      if (adc_start) begin
        ok = 1'b1;
        return;
      end
      if ($urandom_range(0, 3) == 0) begin
        adc_done = 1'b1;
        adc_data = 8'hff;
      end
    end
    total++;
    bad++;
    $display("FAIL start timeout: adc_start=0 after 400 cycles, want 1");
  endtask

  task automatic run_scan(int n, int e, int s, int w, output bit ok,
                          output int clast);
    int smp[4];
    int d;
    int lat;
    smp   = '{n, e, s, w};
    clast = 0;
    for (int i = 0; i < 4; i++) begin
      wait_start(ok);
      if (!ok) return;
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) begin
        adc_done = 1'b1;
        adc_data = 8'hff;
      end
      for (int k = 0; k < lat; k++) begin
        step();
        adc_done = 1'b0;
        adc_data = 8'd0;
      end
      adc_done = 1'b1;
      adc_data = 8'(smp[i]);
      clast    = cyc;
      if (i < 3) begin
        push(0, i + 1, clast + SET + 1);
      end else begin
        d = ref_dir(n, e, s, w);
        push(1, 0, clast + 1);
        if (d >= 0) begin
          push(2, d, clast + 2);
          push(0, 0, clast + 2 + MOV + SET);
        end else begin
          push(0, 0, clast + 2 + SET);
        end
      end
    end
  endtask

  function automatic int near(int base);
    int v;
    v = base + int'($urandom_range(0, 30)) - 15;
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  int tab[8][4] = '{
    '{60, 40, 50, 40},
    '{100, 40, 50, 40},
    '{200, 200, 10, 10},
    '{0, 0, 250, 0},
    '{255, 0, 250, 0},
    '{0, 50, 0, 40},
    '{0, 51, 0, 40},
    '{10, 0, 20, 31}
  };

  initial begin
    bit ok;
    int c;
    int v[4];
    int base;
    ok = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("reset outputs",
        int'({adc_sel, adc_start, scan_done, mn, me, ms, mw}), 0);
    repeat (3) step();
    rst = 1'b0;
    push(0, 0, cyc + SET);

    for (int i = 0; i < 8 && ok; i++) begin
      run_scan(tab[i][0], tab[i][1], tab[i][2], tab[i][3], ok, c);
    end

    for (int i = 0; i < 20 && ok; i++) begin
      base = $urandom_range(0, 255);
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(0, 1) == 1) v[j] = $urandom_range(0, 255);
        else v[j] = near(base);
      end
      run_scan(v[0], v[1], v[2], v[3], ok, c);
    end

    if (ok) begin
      run_scan(0, 0, 0, 200, ok, c);
      if (ok) begin
        while (cyc < c + 8) step();
        chk("mw before reset", int'(mw), 1);
        rst = 1'b1;
        #1;
        chk("async reset outputs",
            int'({adc_sel, adc_start, scan_done, mn, me, ms, mw}), 0);
        q.delete();
        step();
        step();
        rst = 1'b0;
        push(0, 0, cyc + SET);
        wait_start(ok);
        if (ok) chk("rescan sel", int'(adc_sel), 0);
        chk("queue drained", q.size(), 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
